mem_access_unit: RTL and testbench

MEM-stage load/store initiator sitting between the EX_MEM pipeline register and a multi-cycle, handshaked data memory. It accepts one byte, halfword or word access per instruction. It converts the access into a word-aligned bus request with byte enables and stalls the pipeline until the bus completes. For loads it returns a sign- or zero-extended result toward MEM_WB. Misaligned accesses and bus timeouts are reported as faults instead of being issued or left hanging.

---
 rtl/mem_access_unit.sv | 223 ++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Brief    : MEM-stage load/store initiator. Turns one byte/half/word access
//            into a word-aligned handshaked bus request with byte enables,
//            stalls the pipeline until completion, extends load data and
//            reports misalignment / bus timeout as faults.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] ALU_Result,
  input  logic [31:0] Rs2,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] Rd,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  // Last counter value at which the bus may still complete normally.
  localparam logic [CNT_W-1:0] c_last = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       size_q, size_d;
  logic [1:0]       lane_q, lane_d;
  logic             uns_q, uns_d;
  logic             resp_valid_q, resp_valid_d;
  logic             fault_q, fault_d;
  logic [1:0]       fault_cause_q, fault_cause_d;
  logic             mem_req_q, mem_req_d;
  logic             mem_we_q, mem_we_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [3:0]       mem_be_q, mem_be_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;
  logic [31:0]      rd_q, rd_d;

  logic [1:0]       w_size;
  logic             w_misaligned;
  logic [3:0]       w_be;
  logic [31:0]      w_wdata;

  // Select the addressed byte/half of a read word and extend it.
  function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] size,
                                          input logic [1:0] lane, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (size)
      2'd0:    extract = uns ? {24'd0, b} : {{24{b[7]}}, b};
      2'd1:    extract = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: extract = word;
    endcase
  endfunction

  // Decode the incoming request: size 3 behaves as a word access.
  always_comb begin
    w_size       = (req_size == 2'd3) ? 2'd2 : req_size;
    w_misaligned = ((w_size == 2'd1) && ALU_Result[0]) ||
                   ((w_size == 2'd2) && (ALU_Result[1:0] != 2'b00));
    case (w_size)
      2'd0:    begin w_be = 4'b0001 << ALU_Result[1:0]; w_wdata = {4{Rs2[7:0]}};  end
      2'd1:    begin w_be = 4'b0011 << ALU_Result[1:0]; w_wdata = {2{Rs2[15:0]}}; end
      default: begin w_be = 4'b1111;                    w_wdata = Rs2;            end
    endcase
  end

  // Next-state and registered-output logic for the access sequencer.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    size_d        = size_q;
    lane_d        = lane_q;
    uns_d         = uns_q;
    resp_valid_d  = 1'b0;
    fault_d       = 1'b0;
    fault_cause_d = 2'd0;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_be_d      = mem_be_q;
    mem_wdata_d   = mem_wdata_q;
    rd_d          = rd_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (w_misaligned) begin
            state_d       = S_DONE;
            resp_valid_d  = 1'b1;
            fault_d       = 1'b1;
            fault_cause_d = 2'd1;
          end else begin
            state_d     = S_REQ;
            cnt_d       = '0;
            mem_req_d   = 1'b1;
            mem_we_d    = req_we;
            mem_addr_d  = {ALU_Result[31:2], 2'b00};
            mem_be_d    = w_be;
            mem_wdata_d = w_wdata;
            size_d      = w_size;
            lane_d      = ALU_Result[1:0];
            uns_d       = req_unsigned;
          end
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + 1'b1;
        if (mem_gnt) begin
          mem_req_d = 1'b0;
          if (mem_we_q || mem_rvalid) begin
            state_d      = S_DONE;
            resp_valid_d = 1'b1;
            if (!mem_we_q) rd_d = extract(mem_rdata, size_q, lane_q, uns_q);
          end else begin
            state_d = S_WAIT;
          end
        end else if (cnt_q == c_last) begin
          mem_req_d     = 1'b0;
          state_d       = S_DONE;
          resp_valid_d  = 1'b1;
          fault_d       = 1'b1;
          fault_cause_d = 2'd2;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (mem_rvalid) begin
          state_d      = S_DONE;
          resp_valid_d = 1'b1;
          rd_d         = extract(mem_rdata, size_q, lane_q, uns_q);
        end else if (cnt_q == c_last) begin
          state_d       = S_DONE;
          resp_valid_d  = 1'b1;
          fault_d       = 1'b1;
          fault_cause_d = 2'd2;
        end
      end
      default: begin
        // DONE: the completing instruction still holds req_valid; ignore it.
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      size_q        <= 2'd0;
      lane_q        <= 2'd0;
      uns_q         <= 1'b0;
      resp_valid_q  <= 1'b0;
      fault_q       <= 1'b0;
      fault_cause_q <= 2'd0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= 32'd0;
      mem_be_q      <= 4'd0;
      mem_wdata_q   <= 32'd0;
      rd_q          <= 32'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      size_q        <= size_d;
      lane_q        <= lane_d;
      uns_q         <= uns_d;
      resp_valid_q  <= resp_valid_d;
      fault_q       <= fault_d;
      fault_cause_q <= fault_cause_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_be_q      <= mem_be_d;
      mem_wdata_q   <= mem_wdata_d;
      rd_q          <= rd_d;
    end
  end

  // Stall is the only combinational output: it must freeze the pipeline in
  // the very cycle an aligned request is first seen.
  always_comb begin
    stall = (state_q == S_REQ) || (state_q == S_WAIT) ||
            ((state_q == S_IDLE) && req_valid && !w_misaligned);
  end

  assign resp_valid  = resp_valid_q;
  assign fault       = fault_q;
  assign fault_cause = fault_cause_q;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_be      = mem_be_q;
  assign mem_wdata   = mem_wdata_q;
  assign Rd          = rd_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Brief    : Directed self-checking bench for mem_access_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] ALU_Result, Rs2;
  logic        stall, resp_valid, fault, mem_req, mem_we;
  logic [31:0] Rd, mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  fault_cause;
  logic [3:0]  mem_be;
  logic        mem_gnt, mem_rvalid;

  int checks = 0;
  int errors = 0;
  int hi_cnt;

  mem_access_unit #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .ALU_Result(ALU_Result), .Rs2(Rs2),
    .stall(stall), .resp_valid(resp_valid), .Rd(Rd), .fault(fault),
    .fault_cause(fault_cause), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] data);
    req_we = we; req_size = size; req_unsigned = uns; ALU_Result = addr; Rs2 = data;
    req_valid = 1'b1;
  endtask

  // Load with gnt in the first REQ cycle and rvalid one cycle later.
  task automatic load(input string tag, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] rdata,
                      input logic [3:0] exp_be, input logic [31:0] exp_rd);
    issue(1'b0, size, uns, addr, 32'h0);
    mem_gnt = 1'b1;
    tick();
    chk({tag, "_be"}, {28'd0, mem_be}, {28'd0, exp_be});
    chk({tag, "_addr"}, mem_addr, {addr[31:2], 2'b00});
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = rdata;
    tick();
    mem_rvalid = 1'b0; req_valid = 1'b0;
    chk({tag, "_resp"}, {31'd0, resp_valid}, 32'd1);
    chk({tag, "_rd"}, Rd, exp_rd);
    tick();
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    ALU_Result = 32'h0; Rs2 = 32'h0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    tick(); tick();
    chk("rst_outs", {resp_valid, fault, fault_cause, mem_req, mem_we, mem_be, stall},
        32'd0);
    chk("rst_vals", mem_addr | mem_wdata | Rd, 32'd0);
    rst_n = 1'b1;
    tick();

    // LW @0x4, cycle-accurate.
    issue(1'b0, 2'd2, 1'b0, 32'h4, 32'h0);
    #1 chk("lw_stall_c0", {31'd0, stall}, 32'd1);
    mem_gnt = 1'b1;
    tick();
    chk("lw_req_c1", {mem_req, mem_we, mem_be}, {26'd0, 6'b10_1111});
    chk("lw_addr", mem_addr, 32'h4);
    tick();
    mem_gnt = 1'b0;
    chk("lw_wait_c2", {resp_valid, mem_req, stall}, {29'd0, 3'b001});
    mem_rvalid = 1'b1; mem_rdata = 32'h07060504;
    tick();
    mem_rvalid = 1'b0; req_valid = 1'b0;
    chk("lw_resp_c3", {fault, resp_valid, stall}, {29'd0, 3'b010});
    chk("lw_rd", Rd, 32'h07060504);
    tick();
    chk("lw_resp_drop", {31'd0, resp_valid}, 32'd0);

    // Byte/half loads with byte 6 = 0x86.
    load("lb", 2'd0, 1'b0, 32'h6, 32'h07860504, 4'b0100, 32'hFFFFFF86);
    load("lbu", 2'd0, 1'b1, 32'h6, 32'h07860504, 4'b0100, 32'h00000086);
    load("lh", 2'd1, 1'b0, 32'h2, 32'h83820100, 4'b1100, 32'hFFFF8382);
    load("lhu", 2'd1, 1'b1, 32'h2, 32'h83820100, 4'b1100, 32'h00008382);

    // Load where rvalid arrives with gnt: resp after two cycles.
    issue(1'b0, 2'd3, 1'b0, 32'h8, 32'h0);
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h0B0A0908;
    tick();
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b0; req_valid = 1'b0;
    chk("lw_fast_resp", {31'd0, resp_valid}, 32'd1);
    chk("lw_fast_rd", Rd, 32'h0B0A0908);
    tick();

    // SB Rs2=0x123456AB @0x5.
    issue(1'b1, 2'd0, 1'b0, 32'h5, 32'h123456AB);
    mem_gnt = 1'b1;
    tick();
    chk("sb_req", {mem_req, mem_we, mem_be}, {26'd0, 6'b11_0010});
    chk("sb_addr", mem_addr, 32'h4);
    chk("sb_wdata", mem_wdata, 32'hABABABAB);
    tick();
    mem_gnt = 1'b0;
    chk("sb_resp_c2", {fault, resp_valid, stall, mem_req}, {28'd0, 4'b0100});
    chk("sb_rd_keep", Rd, 32'h0B0A0908);
    req_valid = 1'b0;
    tick();

    // SH 0xBEEF @0x6.
    issue(1'b1, 2'd1, 1'b0, 32'h6, 32'h0000BEEF);
    mem_gnt = 1'b1;
    tick();
    chk("sh_be", {28'd0, mem_be}, 32'hC);
    chk("sh_wdata", mem_wdata, 32'hBEEFBEEF);
    tick();
    mem_gnt = 1'b0; req_valid = 1'b0;
    chk("sh_resp", {31'd0, resp_valid}, 32'd1);
    tick();

    // Misaligned LH @0x3, SW @0x2 and size-3 store @0x1.
    issue(1'b0, 2'd1, 1'b0, 32'h3, 32'h0);
    tick();
    req_valid = 1'b0;
    chk("lh_mis", {resp_valid, fault, fault_cause, mem_req}, {27'd0, 5'b11010});
    chk("lh_mis_rd", Rd, 32'h0B0A0908);
    tick();
    chk("lh_mis_drop", {resp_valid, fault, fault_cause}, 32'd0);
    issue(1'b1, 2'd2, 1'b0, 32'h2, 32'hDEADBEEF);
    tick();
    req_valid = 1'b0;
    chk("sw_mis", {resp_valid, fault, fault_cause, mem_req}, {27'd0, 5'b11010});
    tick();
    issue(1'b1, 2'd3, 1'b0, 32'h1, 32'hDEADBEEF);
    tick();
    req_valid = 1'b0;
    chk("s3_mis", {resp_valid, fault, fault_cause, mem_req}, {27'd0, 5'b11010});
    tick();

    // Timeout: gnt never arrives.
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    hi_cnt = 0;
    for (int i = 0; i < 17; i++) begin
      tick();
      if (mem_req) hi_cnt++;
    end
    chk("to_req_cycles", hi_cnt, 32'd16);
    chk("to_fault", {resp_valid, fault, fault_cause, mem_req}, {27'd0, 5'b11100});
    chk("to_rd_keep", Rd, 32'h0B0A0908);
    req_valid = 1'b0; mem_gnt = 1'b1;
    tick();
    tick();
    mem_gnt = 1'b0;
    chk("to_late_gnt", {resp_valid, fault, mem_req, stall}, 32'd0);

    // Asynchronous reset in WAIT, then LW @0x0.
    issue(1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
    mem_gnt = 1'b1;
    tick();
    tick();
    mem_gnt = 1'b0;
    chk("wait_before_rst", {mem_req, stall}, 32'd1);
    #2 rst_n = 1'b0; req_valid = 1'b0;
    #1;
    chk("async_rst_outs", {resp_valid, fault, fault_cause, mem_req, mem_we, mem_be, stall},
        32'd0);
    chk("async_rst_vals", mem_addr | mem_wdata | Rd, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    load("lw_after_rst", 2'd2, 1'b0, 32'h0, 32'h03020100, 4'b1111, 32'h03020100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
